// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter controller.
package ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int RAM_ADDR_W = 7;
  localparam int DEPTH      = 2 ** RAM_ADDR_W;

  // Ceiling log2, never below 1 so a single-bit id always exists.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/ram_arb_ctrl_rr_arbiter.sv
// Round-robin grant: first valid requester at or after the pointer, with wrap.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  logic [ID_W-1:0] ptr;

  // Scan upward from the pointer and take the first valid requester.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!gnt_any && valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
        gnt_any    = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; it holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arb_ctrl.sv
// Arbitrated front end for a single-address RAM: zero-fills after reset,
// then grants one read or write per cycle round-robin.
module ram_arb_ctrl
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 4096,
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        init_done,
  output logic [ADDR_W-1:0]           ram_rd_address,
  output logic [ADDR_W-1:0]           ram_wr_address,
  output logic [DATA_W-1:0]           ram_wr_data,
  output logic                        wr_val,
  input  logic [DATA_W-1:0]           ram_rd_data
);

  localparam int N_WORDS = 2 ** ADDR_W;

  state_e              state, next_state;
  logic [ADDR_W:0]     init_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W-1:0]   wdata_mux;
  logic                wr_en;
  logic [NUM_REQ-1:0]  arb_valid;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_id;
  logic                gnt_any;
  int                  gsel;

  // Stage p0: arbitration and RAM command; stage p1: registered read response.
  logic                vld_p0;
  logic                vld_p1;
  logic [ID_W-1:0]     rsp_id_p1;
  logic [DATA_W-1:0]   rsp_data_p1;

  // Only RUN, outside a reset cycle, may offer grants.
  assign arb_valid = (state == RUN && !rst) ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (arb_valid),
    .grant   (grant),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign req_ready = grant;
  assign gsel      = int'(gnt_id);

  // Next state and RAM command mux; idle cycles keep the last address.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    addr_mux   = addr_q;
    wdata_mux  = '0;
    vld_p0     = 1'b0;
    case (state)
      INIT: begin
        wr_en    = 1'b1;
        addr_mux = init_cnt[ADDR_W-1:0];
        if (init_cnt == (ADDR_W+1)'(N_WORDS - 1)) next_state = RUN;
      end
      RUN: begin
        if (gnt_any) begin
          addr_mux = req_addr[gsel*ADDR_W +: ADDR_W];
          if (req_we[gsel]) begin
            wr_en     = 1'b1;
            wdata_mux = req_wdata[gsel*DATA_W +: DATA_W];
          end else begin
            vld_p0 = 1'b1;
          end
        end
      end
      default: next_state = INIT;
    endcase
    if (rst) begin
      wr_en  = 1'b0;
      vld_p0 = 1'b0;
    end
  end

  assign ram_rd_address = addr_mux;
  assign ram_wr_address = addr_mux;
  assign ram_wr_data    = wdata_mux;
  assign wr_val         = wr_en;
  assign init_done      = (state == RUN);

  // FSM state and zero-fill counter; the extra counter bit keeps wrap unambiguous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Remember the last driven address so idle cycles hold it.
  always_ff @(posedge clk) begin
    addr_q <= addr_mux;
  end

  // Capture read data one cycle after grant; data holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      rsp_id_p1   <= '0;
      rsp_data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        rsp_id_p1   <= gnt_id;
        rsp_data_p1 <= ram_rd_data;
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_id    = rsp_id_p1;
  assign rsp_data  = rsp_data_p1;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Bench for ram_arb_ctrl: RAM model, vector table and scoreboard of read responses.
module tb_ram_arb_ctrl;

  localparam int DATA_W = 4096;
  localparam int ADDR_W = 7;
  localparam int NREQ   = 2;

  logic                     clk;
  logic                     rst;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          req_we;
  logic [NREQ*ADDR_W-1:0]   req_addr;
  logic [NREQ*DATA_W-1:0]   req_wdata;
  logic                     rsp_valid;
  logic [0:0]               rsp_id;
  logic [DATA_W-1:0]        rsp_data;
  logic                     init_done;
  logic [ADDR_W-1:0]        ram_rd_address;
  logic [ADDR_W-1:0]        ram_wr_address;
  logic [DATA_W-1:0]        ram_wr_data;
  logic                     wr_val;
  logic [DATA_W-1:0]        ram_rd_data;

  ram_arb_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .init_done      (init_done),
    .ram_rd_address (ram_rd_address),
    .ram_wr_address (ram_wr_address),
    .ram_wr_data    (ram_wr_data),
    .wr_val         (wr_val),
    .ram_rd_data    (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: starts full of garbage so the zero-fill is observable.
  logic [DATA_W-1:0] ram_mem [128];
  logic              pre_fill;
  always @(posedge clk) begin
    if (pre_fill) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= {64{64'hDEADBEEF0BADF00D}};
    end else if (wr_val) begin
      ram_mem[ram_wr_address] <= ram_wr_data;
    end
  end
  assign ram_rd_data = ram_mem[ram_rd_address];

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  we;
    logic [6:0]  a0;
    logic [6:0]  a1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  rdy;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] data;
  } rsp_t;

  vec_t        tbl[$];
  rsp_t        sb[$];
  logic [63:0] ref_mem [128];
  logic [63:0] last_rsp;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          run_cycles;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DATA_W-1:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== DATA_W'(exp)) begin
      n_fail++;
      $display("FAIL %s: got low64 %h (upper nonzero=%0d), expected %h", nm, act[63:0],
               |act[DATA_W-1:64], exp);
    end
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] we, input logic [6:0] a0,
                         input logic [6:0] a1, input logic [63:0] d0, input logic [63:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {DATA_W'(d1), DATA_W'(d0)};
  endtask

  task automatic add(input logic [1:0] v, input logic [1:0] we, input logic [6:0] a0,
                     input logic [6:0] a1, input logic [63:0] d0, input logic [63:0] d1,
                     input logic [1:0] rdy);
    tbl.push_back(vec_t'{v, we, a0, a1, d0, d1, rdy});
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    sb.delete();
    last_rsp = '0;
  endtask

  // One RUN cycle: called at a negedge with inputs already applied.
  task automatic step(input logic [1:0] exp_rdy, input string nm);
    logic       exp_v;
    logic [6:0] a;
    rsp_t       e;
    #1;
    chk({nm, " ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({nm, " addr_eq"}, 64'(ram_wr_address), 64'(ram_rd_address));
    exp_v = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i]) begin
        a = (i == 0) ? req_addr[6:0] : req_addr[13:7];
        if (req_we[i]) begin
          ref_mem[a] = (i == 0) ? req_wdata[63:0] : req_wdata[DATA_W +: 64];
        end else begin
          sb.push_back(rsp_t'{i, ref_mem[a]});
          exp_v = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    run_cycles++;
    chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(exp_v));
    if (exp_v && sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, " rsp_id"}, 64'(rsp_id), 64'(e.id));
      chk_data({nm, " rsp_data"}, rsp_data, e.data);
      last_rsp = e.data;
    end else if (!exp_v) begin
      chk_data({nm, " rsp_hold"}, rsp_data, last_rsp);
    end
    @(negedge clk);
  endtask

  // Called at the negedge where rst has just fallen; counts edges until init_done.
  task automatic wait_init(input string nm);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      #1;
      if (!init_done) chk({nm, " ready_in_init"}, 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      n++;
      if (init_done) done = 1'b1;
      else @(negedge clk);
    end
    chk({nm, " init_cycles"}, 64'(n), 64'd128);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    pre_fill = 1'b1;
    set_req(2'b00, 2'b00, 7'd0, 7'd0, 64'd0, 64'd0);
    @(posedge clk);
    #1 pre_fill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_id", 64'(rsp_id), 64'd0);
    chk_data("rst rsp_data", rsp_data, 64'd0);
    chk("rst init_done", 64'(init_done), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    wait_init("init1");
    clear_ref();
    run_cycles = 0;

    // Zero-fill readback, write-then-read, alternation, single-requester stream.
    add(2'b01, 2'b00, 7'd0,  7'd0,   64'h0,   64'h0, 2'b01);
    add(2'b01, 2'b00, 7'd64, 7'd0,   64'h0,   64'h0, 2'b01);
    add(2'b10, 2'b00, 7'd0,  7'd127, 64'h0,   64'h0, 2'b10);
    add(2'b01, 2'b01, 7'd5,  7'd0,   64'hA5,  64'h0, 2'b01);
    add(2'b01, 2'b00, 7'd5,  7'd0,   64'h0,   64'h0, 2'b01);
    add(2'b10, 2'b00, 7'd0,  7'd3,   64'h0,   64'h0, 2'b10);
    add(2'b11, 2'b01, 7'd10, 7'd10,  64'h11,  64'h0, 2'b01);
    add(2'b11, 2'b01, 7'd11, 7'd10,  64'h22,  64'h0, 2'b10);
    add(2'b11, 2'b01, 7'd11, 7'd11,  64'h22,  64'h0, 2'b01);
    add(2'b11, 2'b01, 7'd12, 7'd11,  64'h33,  64'h0, 2'b10);
    add(2'b11, 2'b01, 7'd12, 7'd12,  64'h33,  64'h0, 2'b01);
    add(2'b11, 2'b01, 7'd13, 7'd12,  64'h44,  64'h0, 2'b10);
    add(2'b00, 2'b00, 7'd0,  7'd0,   64'h0,   64'h0, 2'b00);
    for (int k = 1; k <= 4; k++)
      add(2'b10, 2'b10, 7'd0, 7'(k), 64'h0, 64'(k * 64'h101), 2'b10);
    for (int k = 1; k <= 4; k++)
      add(2'b10, 2'b00, 7'd0, 7'(k), 64'h0, 64'h0, 2'b10);
    add(2'b00, 2'b00, 7'd0,  7'd0,   64'h0,   64'h0, 2'b00);

    for (int r = 0; r < tbl.size(); r++) begin
      set_req(tbl[r].v, tbl[r].we, tbl[r].a0, tbl[r].a1, tbl[r].d0, tbl[r].d1);
      step(tbl[r].rdy, $sformatf("vec%0d", r));
    end

    // Write addr 9, idle until 40 cycles into RUN, then reset with a read pending.
    set_req(2'b01, 2'b01, 7'd9, 7'd0, 64'hFF, 64'h0);
    step(2'b01, "w9");
    set_req(2'b00, 2'b00, 7'd0, 7'd0, 64'h0, 64'h0);
    while (run_cycles < 40) step(2'b00, "pad");

    rst = 1'b1;
    set_req(2'b11, 2'b00, 7'd9, 7'd9, 64'h0, 64'h0);
    @(posedge clk);
    #1;
    chk("midrun_rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrun_rst init_done", 64'(init_done), 64'd0);
    chk_data("midrun_rst rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_ref();
    wait_init("init2");

    step(2'b01, "first_run");
    step(2'b10, "second_run");
    set_req(2'b00, 2'b00, 7'd0, 7'd0, 64'h0, 64'h0);
    step(2'b00, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arb_ctrl.md
Name: ram_arb_ctrl

Overview:
- Shares the single-port-addressed 4096x128 `ram` between NUM_REQ requesters (default 2), each issuing read or write commands over a valid/ready handshake.
- After reset it zero-fills the whole array, then grants one command per cycle with round-robin fairness.
- Read data returns one cycle after grant, tagged with the requester id.
- Sits directly in front of `ram`; `ram` is the only consumer of its memory-side ports.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- DATA_W, 4096, RAM word width
- ADDR_W, 7, RAM address width; depth = 2**ADDR_W = 128
- ID_W, 1, requester id width, = clog2(NUM_REQ), minimum 1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester command accepted this cycle (one-hot or zero)
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  1  read response valid
- rsp_id  out  ID_W  requester that issued the read
- rsp_data  out  DATA_W  read data
- init_done  out  1  high once zero-fill is complete
- ram_rd_address  out  ADDR_W  to ram
- ram_wr_address  out  ADDR_W  to ram, always equal to ram_rd_address
- ram_wr_data  out  DATA_W  to ram
- wr_val  out  1  ram write enable
- ram_rd_data  in  DATA_W  from ram; combinational read of the addressed word

Behaviour:

Reset:
- State is INIT, init counter = 0, rr pointer = 0.
- Outputs after reset: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, init_done = 0.

FSM, INIT:
- Each cycle: wr_val = 1, address = counter, ram_wr_data = 0, counter++.
- When counter = 2**ADDR_W-1 is written, go to RUN. INIT lasts exactly 128 cycles.
- req_ready = 0 throughout.

FSM, RUN:
- init_done = 1.
- Grant the first valid requester at or after the rr pointer, scanning upward with wrap.
- Grant means req_ready[g] = 1 combinationally in the same cycle. The handshake completes when valid & ready.
- After a grant, rr pointer <= g+1 mod NUM_REQ. With no grant, the pointer holds.

Granted write:
- wr_val = 1, addresses = req_addr[g], ram_wr_data = req_wdata[g]. Data is in RAM at the next edge.

Granted read:
- wr_val = 0, addresses = req_addr[g].
- ram_rd_data is captured into rsp_data at the edge; next cycle rsp_valid = 1, rsp_id = g. Read latency is 1 cycle.

Idle and response rules:
- No grant: wr_val = 0, addresses hold the last value.
- rsp_valid is a single-cycle pulse; there is no response backpressure.
- rsp_data holds its value when rsp_valid = 0.

Boundary conditions:
- Read after write, same address, consecutive cycles: the read returns the new data.
- Requester holding valid: it must keep we/addr/wdata stable until ready. Ready is never given to a non-valid requester.
- Only one requester valid: it is granted every cycle, so back-to-back reads give rsp_valid high continuously.
- rst asserted mid-INIT or mid-RUN: restart INIT next cycle; any pending response is dropped (rsp_valid = 0).
- Address wrap in INIT: the counter is ADDR_W+1 bits so completion detection is unambiguous.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum {INIT, RUN}
  - localparam DEPTH = 2**ADDR_W
  - function clog2
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant from a valid vector and pointer. It is combinational grant logic plus the registered pointer.
- The rest (FSM, muxing, response register) lives in ram_arb_ctrl.

Test Plan:
- Reset release, no requests -> init_done rises exactly 128 cycles after rst falls; then reads of addr 0, 64 and 127 return 0.
- Req0 writes addr 5 = 0xA5 (zero-extended), next cycle req0 reads addr 5 -> one cycle later rsp_valid = 1, rsp_id = 0, rsp_data = 0xA5.
- Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1, with no requester starved and no double grant.
- Req1 alone streams reads of addr 1..4 -> rsp_valid high 4 consecutive cycles with rsp_id = 1 and data in address order.
- rst pulsed for 1 cycle while 40 cycles into RUN after writing addr 9 = 0xFF -> rsp_valid = 0 and init_done = 0 the next cycle, INIT reruns 128 cycles, and a later read of addr 9 returns 0.
- Req valid during INIT -> req_ready stays 0 until init_done; the first grant occurs in the first RUN cycle.
